// File: rtl/pulse_gate_meter.sv
// rtl/pulse_gate_meter.sv - trigger-to-gate delay and gate width meter
// Optional input synchronizers: define PULSE_GATE_METER_SYNC_EN.
module pulse_gate_meter #(
    parameter int CNT_W    = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic             sig,
    output logic [CNT_W-1:0] meas_delay,
    output logic [CNT_W-1:0] meas_dur,
    output logic             meas_valid,
    output logic             dur_ovf,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        PULSE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

    logic trig_in;
    logic sig_in;

`ifdef PULSE_GATE_METER_SYNC_EN
    logic [1:0] trig_sync;
    logic [1:0] sig_sync;

    // Both paths get identical latency, so measured intervals are unaffected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_sync <= 2'b00;
            sig_sync  <= 2'b00;
        end else begin
            trig_sync <= {trig_sync[0], trig};
            sig_sync  <= {sig_sync[0], sig};
        end
    end

    assign trig_in = trig_sync[1];
    assign sig_in  = sig_sync[1];
`else
    assign trig_in = trig;
    assign sig_in  = sig;
`endif

    state_t           state;
    state_t           state_next;
    logic             trig_q;
    logic             sig_q;
    logic             trig_rise;
    logic             sig_rise;
    logic [CNT_W-1:0] delay_cnt;
    logic [CNT_W-1:0] delay_cnt_next;
    logic [CNT_W-1:0] dur_cnt;
    logic [CNT_W-1:0] dur_cnt_next;
    logic             ovf_int;
    logic             ovf_int_next;
    logic [CNT_W-1:0] meas_delay_next;
    logic [CNT_W-1:0] meas_dur_next;
    logic             dur_ovf_next;
    logic             meas_valid_next;
    logic             timeout_next;

    assign trig_rise = trig_in & ~trig_q;
    assign sig_rise  = sig_in & ~sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            trig_q     <= 1'b0;
            sig_q      <= 1'b0;
            delay_cnt  <= '0;
            dur_cnt    <= '0;
            ovf_int    <= 1'b0;
            meas_delay <= '0;
            meas_dur   <= '0;
            dur_ovf    <= 1'b0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            trig_q     <= trig_in;
            sig_q      <= sig_in;
            delay_cnt  <= delay_cnt_next;
            dur_cnt    <= dur_cnt_next;
            ovf_int    <= ovf_int_next;
            meas_delay <= meas_delay_next;
            meas_dur   <= meas_dur_next;
            dur_ovf    <= dur_ovf_next;
            meas_valid <= meas_valid_next;
            timeout    <= timeout_next;
            busy       <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next      = state;
        delay_cnt_next  = delay_cnt;
        dur_cnt_next    = dur_cnt;
        ovf_int_next    = ovf_int;
        meas_delay_next = meas_delay;
        meas_dur_next   = meas_dur;
        dur_ovf_next    = dur_ovf;
        meas_valid_next = 1'b0;
        timeout_next    = 1'b0;

        unique case (state)
            IDLE: begin
                // A gate edge coincident with the trigger is deliberately not seen.
                if (trig_rise) begin
                    delay_cnt_next = CNT_ONE;
                    state_next     = WAIT;
                end
            end
            WAIT: begin
                if (sig_rise) begin
                    meas_delay_next = delay_cnt;
                    dur_cnt_next    = CNT_ONE;
                    ovf_int_next    = 1'b0;
                    state_next      = PULSE;
                end else if (delay_cnt == WAIT_LIM) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    delay_cnt_next = delay_cnt + CNT_ONE;
                end
            end
            PULSE: begin
                if (sig_in) begin
                    if (dur_cnt == CNT_MAX) begin
                        ovf_int_next = 1'b1;
                    end else begin
                        dur_cnt_next = dur_cnt + CNT_ONE;
                    end
                end else begin
                    meas_dur_next   = dur_cnt;
                    dur_ovf_next    = ovf_int;
                    meas_valid_next = 1'b1;
                    ovf_int_next    = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pulse_gate_meter.sv
// tb/tb_pulse_gate_meter.sv - scoreboard bench for pulse_gate_meter
module tb_pulse_gate_meter;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 15;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             trig;
    logic             sig;
    logic [CNT_W-1:0] meas_delay;
    logic [CNT_W-1:0] meas_dur;
    logic             meas_valid;
    logic             dur_ovf;
    logic             timeout;
    logic             busy;

    typedef struct {
        bit is_to;
        int delay;
        int dur;
        int ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   last_delay = 0;
    int   last_dur   = 0;
    int   last_ovf   = 0;

    pulse_gate_meter #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .trig       (trig),
        .sig        (sig),
        .meas_delay (meas_delay),
        .meas_dur   (meas_dur),
        .meas_valid (meas_valid),
        .dur_ovf    (dur_ovf),
        .timeout    (timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_valid(input int delay, input int width);
        exp_t e;
        e.is_to = 1'b0;
        e.delay = delay;
        e.dur   = (width > CNT_MAX) ? CNT_MAX : width;
        e.ovf   = (width > CNT_MAX) ? 1 : 0;
        sb.push_back(e);
        last_delay = e.delay;
        last_dur   = e.dur;
        last_ovf   = e.ovf;
    endtask

    task automatic push_timeout();
        exp_t e;
        e.is_to = 1'b1;
        e.delay = last_delay;
        e.dur   = last_dur;
        e.ovf   = last_ovf;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        chk("sb_drain", sb.size(), 0);
        step();
        step();
    endtask

    // Gate sampled high at edges t0+delay .. t0+delay+width-1.
    task automatic measure(input int delay, input int width, input bit retrig);
        push_valid(delay, width);
        trig = 1'b1;
        step();
        trig = 1'b0;
        chk("busy_wait", busy, 1);
        repeat (delay - 1) step();
        sig = 1'b1;
        for (int i = 0; i < width; i++) begin
            if (retrig && i == 1) trig = 1'b1;
            if (retrig && i == 2) trig = 1'b0;
            step();
            chk("busy_pulse", busy, 1);
        end
        sig = 1'b0;
        step();
        chk("busy_done", busy, 0);
        drain();
    endtask

    task automatic expect_timeout(input bit sig_high);
        push_timeout();
        trig = 1'b1;
        sig  = sig_high;
        step();
        trig = 1'b0;
        repeat (MAX_WAIT - 1) step();
        chk("busy_before_to", busy, 1);
        step();
        chk("busy_after_to", busy, 0);
        drain();
        chk("hold_delay", meas_delay, last_delay);
        chk("hold_dur", meas_dur, last_dur);
    endtask

    always @(negedge clk) begin
        if (!rst && (meas_valid || timeout)) begin
            chk("strobe_excl", int'(meas_valid && timeout), 0);
            chk("strobe_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("strobe_kind", timeout, e.is_to);
                chk("meas_delay", meas_delay, e.delay);
                chk("meas_dur", meas_dur, e.dur);
                chk("dur_ovf", dur_ovf, e.ovf);
            end
        end
    end

    initial begin
        rst  = 1'b1;
        trig = 1'b0;
        sig  = 1'b0;
        #2;
        chk("rst_delay", meas_delay, 0);
        chk("rst_dur", meas_dur, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_ovf", dur_ovf, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_busy", busy, 0);
        step();
        step();
        rst = 1'b0;
        step();
        step();

        measure(3, 5, 1'b0);
        expect_timeout(1'b0);
        measure(1, 20, 1'b0);
        measure(2, 4, 1'b1);
        measure(4, 2, 1'b0);
        measure(MAX_WAIT, 1, 1'b0);

        // Gate already high when the trigger rises: no rise seen, so timeout.
        expect_timeout(1'b1);
        sig = 1'b0;
        step();
        step();

        // Gate high at t0, drops, then rises again at t0+6.
        push_valid(6, 3);
        trig = 1'b1;
        sig  = 1'b1;
        step();
        trig = 1'b0;
        step();
        sig = 1'b0;
        repeat (4) step();
        sig = 1'b1;
        repeat (3) step();
        sig = 1'b0;
        step();
        drain();

        // Reset in the middle of a gate pulse.
        trig = 1'b1;
        step();
        trig = 1'b0;
        step();
        step();
        sig = 1'b1;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_delay", meas_delay, 0);
        chk("mid_rst_dur", meas_dur, 0);
        chk("mid_rst_valid", meas_valid, 0);
        chk("mid_rst_ovf", dur_ovf, 0);
        chk("mid_rst_timeout", timeout, 0);
        chk("mid_rst_busy", busy, 0);
        last_delay = 0;
        last_dur   = 0;
        last_ovf   = 0;
        step();
        sig = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        chk("post_rst_busy", busy, 0);
        measure(3, 5, 1'b0);

        chk("sb_final", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
